cam_ctrl: RTL and testbench

- Sequencing controller for the 8-entry, 4-bit key match table.
- Owns the entry registers, per-entry valid bits and the replacement pointer.
- Services one SEARCH / INSERT / DELETE / CLEAR request at a time over a valid/ready handshake.
- Returns hit, index and eviction status after a fixed latency. It sits between the lab's command source and the match datapath.

---
 rtl/cam_ctrl.sv | 152 +++++++++++++++
 tb/tb_cam_ctrl.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_ctrl.sv
// Sequencing controller for a small key match table: owns the entries, valid
// bits and round-robin replacement pointer; serves one request per 4 cycles.
module cam_ctrl #(
  parameter  int ENTRIES = 8,
  parameter  int KEY_W   = 4,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_op,
  input  logic [KEY_W-1:0]   req_key,
  output logic               rsp_valid,
  output logic               rsp_hit,
  output logic [IDX_W-1:0]   rsp_idx,
  output logic               rsp_evict,
  output logic [ENTRIES-1:0] match_vec,
  output logic [3:0]         entry_cnt,
  output logic               full,
  output logic               empty,
  output logic [1:0]         dbg_state
);

  localparam logic [1:0] OP_SEARCH = 2'b00;
  localparam logic [1:0] OP_INSERT = 2'b01;
  localparam logic [1:0] OP_DELETE = 2'b10;
  localparam logic [1:0] OP_CLEAR  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPARE = 2'd1,
    S_UPDATE  = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [1:0]         op_q;
  logic [KEY_W-1:0]   key_q;
  logic [KEY_W-1:0]   entry [ENTRIES];
  logic [ENTRIES-1:0] valid;
  logic [IDX_W-1:0]   rr_ptr;

  logic               hit;
  logic [IDX_W-1:0]   hidx;
  logic [IDX_W-1:0]   free_idx;
  logic [3:0]         cnt;

  // Handshake: a request transfers on a rising edge where req_valid and
  // req_ready are both high; req_ready is high only in IDLE, so a requester
  // seeing it low must hold its request. rsp_valid is a one-cycle strobe
  // with no backpressure.
  assign req_ready = (state == S_IDLE);
  assign dbg_state = state;

  // Lowest matching entry, lowest free entry and occupancy count.
  always_comb begin
    hit      = |match_vec;
    hidx     = '0;
    free_idx = '0;
    cnt      = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (match_vec[i]) hidx = IDX_W'(i);
      if (!valid[i])    free_idx = IDX_W'(i);
    end
    for (int i = 0; i < ENTRIES; i++) cnt = cnt + 4'(valid[i]);
  end

  assign entry_cnt = cnt;
  assign full      = (cnt == 4'(ENTRIES));
  assign empty     = (cnt == 4'd0);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (req_valid) state_nxt = S_COMPARE;
      S_COMPARE: state_nxt = S_UPDATE;
      S_UPDATE:  state_nxt = S_RESP;
      S_RESP:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= OP_SEARCH;
      key_q     <= '0;
      valid     <= '0;
      rr_ptr    <= '0;
      match_vec <= '0;
      rsp_valid <= 1'b0;
      rsp_hit   <= 1'b0;
      rsp_idx   <= '0;
      rsp_evict <= 1'b0;
      for (int i = 0; i < ENTRIES; i++) entry[i] <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_q  <= req_op;
            key_q <= req_key;
          end
        end
        S_COMPARE: begin
          for (int i = 0; i < ENTRIES; i++)
            match_vec[i] <= valid[i] && (entry[i] == key_q);
        end
        S_UPDATE: begin
          // Response fields are loaded here and held until the next UPDATE.
          rsp_valid <= 1'b1;
          rsp_hit   <= hit;
          rsp_idx   <= hidx;
          rsp_evict <= 1'b0;
          case (op_q)
            OP_INSERT: begin
              if (!hit) begin
                if (!full) begin
                  entry[free_idx] <= key_q;
                  valid[free_idx] <= 1'b1;
                  rsp_idx         <= free_idx;
                end else begin
                  entry[rr_ptr] <= key_q;
                  rsp_evict     <= 1'b1;
                  rsp_idx       <= rr_ptr;
                  rr_ptr        <= rr_ptr + IDX_W'(1);
                end
              end
            end
            OP_DELETE: begin
              if (hit) valid[hidx] <= 1'b0;
            end
            OP_CLEAR: begin
              valid   <= '0;
              rr_ptr  <= '0;
              rsp_hit <= 1'b0;
              rsp_idx <= '0;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_ctrl.sv
// Self-checking bench for cam_ctrl: a reference table model feeds an expected
// response queue; scenario tasks add literal checks of status outputs.
module tb_cam_ctrl;

  localparam int ENTRIES = 8;
  localparam int KEY_W   = 4;
  localparam logic [1:0] OP_SEARCH = 2'b00;
  localparam logic [1:0] OP_INSERT = 2'b01;
  localparam logic [1:0] OP_DELETE = 2'b10;
  localparam logic [1:0] OP_CLEAR  = 2'b11;

  logic               clk;
  logic               rst_n;
  logic               req_valid;
  logic               req_ready;
  logic [1:0]         req_op;
  logic [KEY_W-1:0]   req_key;
  logic               rsp_valid;
  logic               rsp_hit;
  logic [2:0]         rsp_idx;
  logic               rsp_evict;
  logic [ENTRIES-1:0] match_vec;
  logic [3:0]         entry_cnt;
  logic               full;
  logic               empty;
  logic [1:0]         dbg_state;

  int tests = 0;
  int fails = 0;

  // Expected response {hit, idx[2:0], evict}
  logic [4:0] exp_q[$];

  logic             m_valid [ENTRIES];
  logic [KEY_W-1:0] m_key   [ENTRIES];
  int               m_rr;

  cam_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_key   (req_key),
    .rsp_valid (rsp_valid),
    .rsp_hit   (rsp_hit),
    .rsp_idx   (rsp_idx),
    .rsp_evict (rsp_evict),
    .match_vec (match_vec),
    .entry_cnt (entry_cnt),
    .full      (full),
    .empty     (empty),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog expired");
  end

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_key[i]   = '0;
    end
    m_rr = 0;
  endtask

  function automatic int model_cnt();
    int c;
    c = 0;
    for (int i = 0; i < ENTRIES; i++) if (m_valid[i]) c++;
    return c;
  endfunction

  task automatic model_step(input logic [1:0] op, input logic [KEY_W-1:0] key,
                            output logic [4:0] r);
    logic hit;
    int   hidx;
    int   free;
    hit  = 1'b0;
    hidx = 0;
    free = -1;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!m_valid[i] && free < 0) free = i;
      if (!hit && m_valid[i] && m_key[i] == key) begin
        hit  = 1'b1;
        hidx = i;
      end
    end
    r = '0;
    case (op)
      OP_SEARCH: r = {hit, 3'(hidx), 1'b0};
      OP_INSERT: begin
        if (hit) r = {1'b1, 3'(hidx), 1'b0};
        else if (free >= 0) begin
          m_key[free]   = key;
          m_valid[free] = 1'b1;
          r = {1'b0, 3'(free), 1'b0};
        end else begin
          m_key[m_rr] = key;
          r = {1'b0, 3'(m_rr), 1'b1};
          m_rr = (m_rr + 1) % ENTRIES;
        end
      end
      OP_DELETE: begin
        if (hit) m_valid[hidx] = 1'b0;
        r = {hit, 3'(hidx), 1'b0};
      end
      default: begin
        for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
        m_rr = 0;
        r = '0;
      end
    endcase
  endtask

  // Scoreboard: every response strobe must match the oldest expectation.
  always @(negedge clk) begin
    logic [4:0] e;
    if (rst_n && rsp_valid) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL rsp_unexpected: got strobe hit=%0b idx=%0d evict=%0b, required no response",
                 rsp_hit, rsp_idx, rsp_evict);
      end else begin
        e = exp_q.pop_front();
        if ({rsp_hit, rsp_idx, rsp_evict} !== e) begin
          fails++;
          $display("FAIL rsp_fields: got hit=%0b idx=%0d evict=%0b, required hit=%0b idx=%0d evict=%0b",
                   rsp_hit, rsp_idx, rsp_evict, e[4], e[3:1], e[0]);
        end
      end
    end
  end

  // Driver tasks
  task automatic apply_reset();
    rst_n     = 1'b0;
    req_valid = 1'b0;
    exp_q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [1:0] op, input logic [KEY_W-1:0] key);
    logic [4:0] e;
    int n;
    model_step(op, key, e);
    exp_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_key   = key;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (!req_ready) begin
      fails++;
      $display("FAIL send_ready_timeout: req_ready=%0b after %0d cycles, required 1", req_ready, n);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk);
      #2;
      n++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_rsp_timeout: %0d responses outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_op(input logic [1:0] op, input logic [KEY_W-1:0] key, input string name);
    send(op, key);
    wait_rsp(name);
  endtask

  // Scenarios
  task automatic test_reset();
    req_op  = OP_SEARCH;
    req_key = '0;
    apply_reset();
    #1;
    tests++;
    if ({req_ready, rsp_valid, rsp_hit, rsp_idx, rsp_evict} !== 7'b1000000) begin
      fails++;
      $display("FAIL reset_rsp: got ready/valid/hit/idx/evict=%b, required 1000000",
               {req_ready, rsp_valid, rsp_hit, rsp_idx, rsp_evict});
    end
    tests++;
    if ({match_vec, entry_cnt, full, empty, dbg_state} !== {8'h00, 4'd0, 1'b0, 1'b1, 2'd0}) begin
      fails++;
      $display("FAIL reset_status: got match=%h cnt=%0d full=%0b empty=%0b state=%0d, required 00 0 0 1 0",
               match_vec, entry_cnt, full, empty, dbg_state);
    end
  endtask

  task automatic test_insert_search();
    do_op(OP_INSERT, 4'hA, "ins_a");
    tests++;
    if ({rsp_hit, rsp_idx, rsp_evict, entry_cnt, empty} !== {1'b0, 3'd0, 1'b0, 4'd1, 1'b0}) begin
      fails++;
      $display("FAIL ins_a: got hit=%0b idx=%0d evict=%0b cnt=%0d empty=%0b, required 0 0 0 1 0",
               rsp_hit, rsp_idx, rsp_evict, entry_cnt, empty);
    end
    do_op(OP_INSERT, 4'hA, "ins_a_dup");
    tests++;
    if ({rsp_hit, rsp_idx, rsp_evict, entry_cnt} !== {1'b1, 3'd0, 1'b0, 4'd1}) begin
      fails++;
      $display("FAIL ins_a_dup: got hit=%0b idx=%0d evict=%0b cnt=%0d, required 1 0 0 1",
               rsp_hit, rsp_idx, rsp_evict, entry_cnt);
    end
    do_op(OP_SEARCH, 4'hA, "srch_a");
    tests++;
    if ({rsp_hit, rsp_idx, match_vec} !== {1'b1, 3'd0, 8'h01}) begin
      fails++;
      $display("FAIL srch_a: got hit=%0b idx=%0d match=%h, required 1 0 01", rsp_hit, rsp_idx, match_vec);
    end
    do_op(OP_SEARCH, 4'h5, "srch_5");
    tests++;
    if ({rsp_hit, match_vec} !== {1'b0, 8'h00}) begin
      fails++;
      $display("FAIL srch_5: got hit=%0b match=%h, required 0 00", rsp_hit, match_vec);
    end
    do_op(OP_DELETE, 4'h5, "del_miss");
    tests++;
    if ({rsp_hit, rsp_idx, entry_cnt} !== {1'b0, 3'd0, 4'd1}) begin
      fails++;
      $display("FAIL del_miss: got hit=%0b idx=%0d cnt=%0d, required 0 0 1", rsp_hit, rsp_idx, entry_cnt);
    end
  endtask

  task automatic test_fill_evict();
    apply_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      do_op(OP_INSERT, 4'(i), "fill");
      tests++;
      if ({rsp_idx, rsp_evict} !== {3'(i), 1'b0}) begin
        fails++;
        $display("FAIL fill_idx: got idx=%0d evict=%0b, required %0d 0", rsp_idx, rsp_evict, i);
      end
    end
    tests++;
    if ({full, entry_cnt} !== {1'b1, 4'd8}) begin
      fails++;
      $display("FAIL fill_full: got full=%0b cnt=%0d, required 1 8", full, entry_cnt);
    end
    do_op(OP_INSERT, 4'hF, "evict_f");
    tests++;
    if ({rsp_hit, rsp_idx, rsp_evict} !== {1'b0, 3'd0, 1'b1}) begin
      fails++;
      $display("FAIL evict_f: got hit=%0b idx=%0d evict=%0b, required 0 0 1", rsp_hit, rsp_idx, rsp_evict);
    end
    do_op(OP_INSERT, 4'hE, "evict_e");
    tests++;
    if ({rsp_idx, rsp_evict, entry_cnt} !== {3'd1, 1'b1, 4'd8}) begin
      fails++;
      $display("FAIL evict_e: got idx=%0d evict=%0b cnt=%0d, required 1 1 8", rsp_idx, rsp_evict, entry_cnt);
    end
  endtask

  task automatic test_delete_reuse();
    apply_reset();
    for (int i = 0; i < ENTRIES; i++) do_op(OP_INSERT, 4'(i + 8), "fill_hi");
    do_op(OP_DELETE, 4'hB, "del_b");
    tests++;
    if ({rsp_hit, rsp_idx, entry_cnt, full} !== {1'b1, 3'd3, 4'd7, 1'b0}) begin
      fails++;
      $display("FAIL del_b: got hit=%0b idx=%0d cnt=%0d full=%0b, required 1 3 7 0",
               rsp_hit, rsp_idx, entry_cnt, full);
    end
    do_op(OP_INSERT, 4'h1, "reuse_1");
    tests++;
    if ({rsp_idx, rsp_evict, entry_cnt} !== {3'd3, 1'b0, 4'd8}) begin
      fails++;
      $display("FAIL reuse_1: got idx=%0d evict=%0b cnt=%0d, required 3 0 8", rsp_idx, rsp_evict, entry_cnt);
    end
    do_op(OP_INSERT, 4'h2, "rr_unchanged");
    tests++;
    if ({rsp_idx, rsp_evict} !== {3'd0, 1'b1}) begin
      fails++;
      $display("FAIL rr_unchanged: got idx=%0d evict=%0b, required 0 1", rsp_idx, rsp_evict);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] e;
    logic [1:0] op;
    logic [KEY_W-1:0] key;
    apply_reset();
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      tests++;
      if (req_ready !== (k % 4 == 0)) begin
        fails++;
        $display("FAIL b2b_ready: cycle %0d got req_ready=%0b, required %0b", k, req_ready, (k % 4 == 0));
      end
      if (req_ready) begin
        op  = 2'($urandom_range(0, 2));
        key = 4'($urandom_range(0, 3));
        model_step(op, key, e);
        exp_q.push_back(e);
        req_op    = op;
        req_key   = key;
        req_valid = 1'b1;
      end
    end
    req_valid = 1'b0;
    wait_rsp("b2b");
  endtask

  task automatic test_clear();
    apply_reset();
    for (int i = 0; i < ENTRIES; i++) do_op(OP_INSERT, 4'(i + 3), "fill_c");
    do_op(OP_CLEAR, 4'h3, "clear");
    tests++;
    if ({empty, full, entry_cnt, rsp_hit, rsp_idx} !== {1'b1, 1'b0, 4'd0, 1'b0, 3'd0}) begin
      fails++;
      $display("FAIL clear: got empty=%0b full=%0b cnt=%0d hit=%0b idx=%0d, required 1 0 0 0 0",
               empty, full, entry_cnt, rsp_hit, rsp_idx);
    end
    do_op(OP_SEARCH, 4'h3, "srch_cleared");
    tests++;
    if ({rsp_hit, match_vec} !== {1'b0, 8'h00}) begin
      fails++;
      $display("FAIL srch_cleared: got hit=%0b match=%h, required 0 00", rsp_hit, match_vec);
    end
  endtask

  task automatic test_reset_mid_op();
    apply_reset();
    do_op(OP_INSERT, 4'h9, "pre_abort");
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = OP_INSERT;
    req_key   = 4'h7;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (dbg_state !== 2'd2) begin
      fails++;
      $display("FAIL abort_in_update: got state=%0d, required 2", dbg_state);
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    tests++;
    if ({rsp_valid, entry_cnt, req_ready, empty} !== {1'b0, 4'd0, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL abort_reset: got valid=%0b cnt=%0d ready=%0b empty=%0b, required 0 0 1 1",
               rsp_valid, entry_cnt, req_ready, empty);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      tests++;
      if ({rsp_valid, entry_cnt, req_ready} !== {1'b0, 4'd0, 1'b1}) begin
        fails++;
        $display("FAIL abort_after: got valid=%0b cnt=%0d ready=%0b, required 0 0 1",
                 rsp_valid, entry_cnt, req_ready);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] op;
    int c;
    apply_reset();
    for (int n = 0; n < 40; n++) begin
      op = ($urandom_range(0, 15) == 0) ? OP_CLEAR : 2'($urandom_range(0, 2));
      do_op(op, 4'($urandom_range(0, 9)), "rand");
      c = model_cnt();
      tests++;
      if ({entry_cnt, full, empty} !== {4'(c), (c == ENTRIES), (c == 0)}) begin
        fails++;
        $display("FAIL rand_status: got cnt=%0d full=%0b empty=%0b, required cnt=%0d", entry_cnt, full, empty, c);
      end
    end
  endtask

  // Sequence and report
  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    test_reset();
    test_insert_search();
    test_fill_evict();
    test_delete_reuse();
    test_back_to_back();
    test_clear();
    test_reset_mid_op();
    test_random();
    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
